key_action_ctrl: RTL and testbench



---
 rtl/key_action_ctrl.sv | 243 ++++++++++++++++++++++++
 tb/tb_key_action_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/key_action_ctrl.sv
// key_action_ctrl: keycode decode, edge detect, auto-repeat and hold lockout.
// Optional Esc pause feature: define KEY_ACTION_PAUSE_EN.
module key_action_ctrl #(
   parameter int unsigned DAS_FRAMES  = 10,
   parameter int unsigned ARR_FRAMES  = 2,
   parameter int unsigned SOFT_FRAMES = 3
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        frame_tick,
   input  logic [15:0] keycode,
   input  logic        touchdown,
   input  logic        endgame,
   output logic        move_left,
   output logic        move_right,
   output logic        soft_drop,
   output logic        rotate_cw,
   output logic        rotate_ccw,
   output logic        hard_drop,
   output logic        hold_req,
`ifdef KEY_ACTION_PAUSE_EN
   output logic        pause,
`endif
   output logic        hold_locked
);

   localparam int K_L = 0, K_R = 1, K_SD = 2, K_CW = 3;
   localparam int K_CCW = 4, K_HD = 5, K_HOLD = 6;
`ifdef KEY_ACTION_PAUSE_EN
   localparam int K_ESC = 7;
   localparam int NK = 8;
`else
   localparam int NK = 7;
`endif

   localparam logic [4:0] DAS_L =
      (DAS_FRAMES == 0) ? 5'd1 : 5'(DAS_FRAMES);
   localparam logic [4:0] ARR_L =
      (ARR_FRAMES == 0) ? 5'd1 : 5'(ARR_FRAMES);
   localparam logic [4:0] SOFT_L =
      (SOFT_FRAMES == 0) ? 5'd1 : 5'(SOFT_FRAMES);

   typedef enum logic [1:0] {H_IDLE, H_DELAY, H_REPEAT} h_state_e;
   typedef enum logic {S_IDLE, S_REPEAT} s_state_e;

   h_state_e h_q, h_d;
   s_state_e s_q, s_d;
   logic [4:0] hcnt_q, hcnt_d, scnt_q, scnt_d, hdec, sdec;
   logic hdir_q, hdir_d, hpend_q, hpend_d;
   logic locked_q, locked_d;
   logic [NK-1:0] prs, prev_q, edges;
   logic ml_q, ml_d, mr_q, mr_d, sd_q, sd_d, cw_q, cw_d;
   logic ccw_q, ccw_d, hd_q, hd_d, hold_q, hold_d;
   logic dir_v, dir_l, prev_v, dir_edge, freeze;
`ifdef KEY_ACTION_PAUSE_EN
   logic pause_q, pause_d;
`endif

   function automatic logic hit(input logic [15:0] kc,
                                input logic [7:0]  code);
      return (kc[7:0] == code) || (kc[15:8] == code);
   endfunction

   // decode both keycode bytes into a pressed vector and its rising edges
   always_comb begin
      prs         = '0;
      prs[K_L]    = hit(keycode, 8'h04);
      prs[K_R]    = hit(keycode, 8'h07);
      prs[K_SD]   = hit(keycode, 8'h16);
      prs[K_CW]   = hit(keycode, 8'h1A);
      prs[K_CCW]  = hit(keycode, 8'h14);
      prs[K_HD]   = hit(keycode, 8'h2C);
      prs[K_HOLD] = hit(keycode, 8'h13);
`ifdef KEY_ACTION_PAUSE_EN
      prs[K_ESC]  = hit(keycode, 8'h29);
`endif
      edges    = prs & ~prev_q;
      dir_v    = prs[K_L] ^ prs[K_R];
      dir_l    = prs[K_L];
      prev_v   = prev_q[K_L] ^ prev_q[K_R];
      dir_edge = dir_v && (!prev_v || (prev_q[K_L] != dir_l));
      hdec     = (hcnt_q == 5'd0) ? 5'd0 : hcnt_q - 5'd1;
      sdec     = (scnt_q == 5'd0) ? 5'd0 : scnt_q - 5'd1;
   end

   // next-state for both repeat FSMs, hold lockout and action pulses
   always_comb begin
      h_d      = h_q;
      hcnt_d   = hcnt_q;
      hdir_d   = hdir_q;
      hpend_d  = 1'b0;
      s_d      = s_q;
      scnt_d   = scnt_q;
      locked_d = locked_q;
      ml_d     = 1'b0;
      mr_d     = 1'b0;
      sd_d     = 1'b0;
      cw_d     = 1'b0;
      ccw_d    = 1'b0;
      hd_d     = 1'b0;
      hold_d   = 1'b0;
      freeze   = 1'b0;
`ifdef KEY_ACTION_PAUSE_EN
      pause_d  = pause_q;
      if (edges[K_ESC]) pause_d = ~pause_q;
      freeze   = pause_q | edges[K_ESC];
      if (pause_q && edges[K_ESC]) begin
         h_d    = H_IDLE;
         hcnt_d = 5'd0;
         s_d    = S_IDLE;
         scnt_d = 5'd0;
      end
`endif
      if (endgame) begin
         h_d      = H_IDLE;
         hcnt_d   = 5'd0;
         s_d      = S_IDLE;
         scnt_d   = 5'd0;
         locked_d = 1'b0;
`ifdef KEY_ACTION_PAUSE_EN
         pause_d  = 1'b0;
`endif
      end else if (freeze) begin
         if (touchdown) locked_d = 1'b0;
      end else begin
         cw_d   = edges[K_CW];
         ccw_d  = edges[K_CCW];
         hd_d   = edges[K_HD];
         hold_d = edges[K_HOLD] & ~locked_q;
         if (touchdown)   locked_d = 1'b0;
         else if (hold_d) locked_d = 1'b1;

         unique case (h_q)
            H_IDLE: begin
               if (dir_v && (dir_edge || hpend_q)) begin
                  ml_d   = dir_l;
                  mr_d   = ~dir_l;
                  hdir_d = dir_l;
                  hcnt_d = DAS_L;
                  h_d    = H_DELAY;
               end
            end
            H_DELAY, H_REPEAT: begin
               if (!dir_v || (dir_l != hdir_q)) begin
                  h_d     = H_IDLE;
                  hcnt_d  = 5'd0;
                  hpend_d = dir_v;
               end else if (frame_tick) begin
                  hcnt_d = hdec;
                  if (hdec == 5'd0) begin
                     ml_d   = hdir_q;
                     mr_d   = ~hdir_q;
                     hcnt_d = ARR_L;
                     h_d    = H_REPEAT;
                  end
               end
            end
            default: begin
               h_d    = H_IDLE;
               hcnt_d = 5'd0;
            end
         endcase

         unique case (s_q)
            S_IDLE: begin
               if (edges[K_SD]) begin
                  sd_d   = 1'b1;
                  scnt_d = SOFT_L;
                  s_d    = S_REPEAT;
               end
            end
            S_REPEAT: begin
               if (!prs[K_SD]) begin
                  s_d    = S_IDLE;
                  scnt_d = 5'd0;
               end else if (frame_tick) begin
                  scnt_d = sdec;
                  if (sdec == 5'd0) begin
                     sd_d   = 1'b1;
                     scnt_d = SOFT_L;
                  end
               end
            end
         endcase
      end
   end

   // state, counters, previous-pressed and registered pulses
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         h_q      <= H_IDLE;
         s_q      <= S_IDLE;
         hcnt_q   <= 5'd0;
         scnt_q   <= 5'd0;
         hdir_q   <= 1'b0;
         hpend_q  <= 1'b0;
         locked_q <= 1'b0;
         prev_q   <= '0;
         ml_q     <= 1'b0;
         mr_q     <= 1'b0;
         sd_q     <= 1'b0;
         cw_q     <= 1'b0;
         ccw_q    <= 1'b0;
         hd_q     <= 1'b0;
         hold_q   <= 1'b0;
`ifdef KEY_ACTION_PAUSE_EN
         pause_q  <= 1'b0;
`endif
      end else begin
         h_q      <= h_d;
         s_q      <= s_d;
         hcnt_q   <= hcnt_d;
         scnt_q   <= scnt_d;
         hdir_q   <= hdir_d;
         hpend_q  <= hpend_d;
         locked_q <= locked_d;
         prev_q   <= prs;
         ml_q     <= ml_d;
         mr_q     <= mr_d;
         sd_q     <= sd_d;
         cw_q     <= cw_d;
         ccw_q    <= ccw_d;
         hd_q     <= hd_d;
         hold_q   <= hold_d;
`ifdef KEY_ACTION_PAUSE_EN
         pause_q  <= pause_d;
`endif
      end
   end

   assign move_left   = ml_q;
   assign move_right  = mr_q;
   assign soft_drop   = sd_q;
   assign rotate_cw   = cw_q;
   assign rotate_ccw  = ccw_q;
   assign hard_drop   = hd_q;
   assign hold_req    = hold_q;
   assign hold_locked = locked_q;
`ifdef KEY_ACTION_PAUSE_EN
   assign pause       = pause_q;
`endif

endmodule

// File: tb/tb_key_action_ctrl.sv
// Directed self-checking bench for key_action_ctrl (default parameters).
// Pause scenario is exercised when KEY_ACTION_PAUSE_EN is defined.
module tb_key_action_ctrl;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_tick = 1'b0;
   logic [15:0] keycode = 16'h0000;
   logic        touchdown = 1'b0;
   logic        endgame = 1'b0;
   logic        move_left, move_right, soft_drop;
   logic        rotate_cw, rotate_ccw, hard_drop;
   logic        hold_req, hold_locked;
`ifdef KEY_ACTION_PAUSE_EN
   logic        pause;
`endif

   int checks = 0;
   int failures = 0;
   int n_l, n_r, n_sd, n_cw, n_hd, n_hold;

   key_action_ctrl dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .keycode    (keycode),
      .touchdown  (touchdown),
      .endgame    (endgame),
      .move_left  (move_left),
      .move_right (move_right),
      .soft_drop  (soft_drop),
      .rotate_cw  (rotate_cw),
      .rotate_ccw (rotate_ccw),
      .hard_drop  (hard_drop),
      .hold_req   (hold_req),
`ifdef KEY_ACTION_PAUSE_EN
      .pause      (pause),
`endif
      .hold_locked(hold_locked)
   );

   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      n_l = 0; n_r = 0; n_sd = 0; n_cw = 0; n_hd = 0; n_hold = 0;
   endtask

   task automatic cyc();
      @(posedge Clk);
      #1;
      n_l    += int'(move_left);
      n_r    += int'(move_right);
      n_sd   += int'(soft_drop);
      n_cw   += int'(rotate_cw);
      n_hd   += int'(hard_drop);
      n_hold += int'(hold_req);
   endtask

   task automatic frame();
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
   endtask

   initial begin
      clr();
      // reset state
      cyc(); cyc();
      chk("reset_pulses", {24'd0, move_left, move_right, soft_drop,
          rotate_cw, rotate_ccw, hard_drop, hold_req, 1'b0}, 32'd0);
      chk("reset_locked", {31'd0, hold_locked}, 32'd0);
      Reset = 1'b0;
      cyc(); cyc();

      // left held for 40 frames: 1 + 1 + 15 pulses
      clr();
      keycode = 16'h0004;
      cyc();
      chk("left_first", {31'd0, move_left}, 32'd1);
      for (int i = 1; i <= 40; i++) begin
         frame_tick = 1'b1;
         cyc();
         frame_tick = 1'b0;
         if (i == 9)  chk("left_tick9", {31'd0, move_left}, 32'd0);
         if (i == 10) chk("left_tick10", {31'd0, move_left}, 32'd1);
         cyc();
         cyc();
      end
      keycode = 16'h0000;
      cyc(); cyc();
      chk("left_total", n_l, 32'd17);
      chk("right_none", n_r, 32'd0);

      // left+right cancels, releasing right yields a left edge
      clr();
      keycode = 16'h0704;
      cyc();
      chk("lr_none1", {30'd0, move_left, move_right}, 32'd0);
      cyc();
      chk("lr_none2", {30'd0, move_left, move_right}, 32'd0);
      keycode = 16'h0004;
      cyc();
      chk("lr_release_r", {30'd0, move_left, move_right}, 32'd2);
      keycode = 16'h0000;
      cyc(); cyc();

      // hold lockout until touchdown
      clr();
      keycode = 16'h0013;
      cyc();
      chk("hold_first", {31'd0, hold_req}, 32'd1);
      cyc();
      chk("hold_locked1", {31'd0, hold_locked}, 32'd1);
      keycode = 16'h0000;
      cyc();
      keycode = 16'h0013;
      cyc();
      chk("hold_discard", {31'd0, hold_req}, 32'd0);
      keycode = 16'h0000;
      cyc();
      chk("hold_locked2", {31'd0, hold_locked}, 32'd1);
      chk("hold_count", n_hold, 32'd1);
      touchdown = 1'b1;
      cyc();
      touchdown = 1'b0;
      chk("touch_unlock", {31'd0, hold_locked}, 32'd0);
      keycode = 16'h0013;
      cyc();
      chk("hold_second", {31'd0, hold_req}, 32'd1);
      keycode = 16'h0000;
      cyc();

      // hold edge and touchdown in the same cycle
      touchdown = 1'b1;
      cyc();
      keycode = 16'h0013;
      cyc();
      chk("hold_td_req", {31'd0, hold_req}, 32'd1);
      chk("hold_td_lock", {31'd0, hold_locked}, 32'd0);
      touchdown = 1'b0;
      keycode = 16'h0000;
      cyc();

      // rotate_cw + hard_drop in one cycle, once while held
      clr();
      keycode = 16'h2C1A;
      cyc();
      chk("cw_hd_same", {30'd0, rotate_cw, hard_drop}, 32'd3);
      for (int i = 0; i < 6; i++) cyc();
      chk("cw_count", n_cw, 32'd1);
      chk("hd_count", n_hd, 32'd1);
      keycode = 16'h0000;
      cyc();

      // endgame clears hold_locked
      keycode = 16'h0013;
      cyc();
      keycode = 16'h0000;
      cyc();
      chk("eg_lock_before", {31'd0, hold_locked}, 32'd1);
      endgame = 1'b1;
      cyc();
      chk("eg_lock_clear", {31'd0, hold_locked}, 32'd0);

      // soft drop held through endgame deassertion
      clr();
      keycode = 16'h0016;
      cyc();
      chk("eg_soft_off", {31'd0, soft_drop}, 32'd0);
      endgame = 1'b0;
      for (int i = 0; i < 10; i++) frame();
      chk("eg_soft_none", n_sd, 32'd0);
      keycode = 16'h0000;
      cyc();
      keycode = 16'h0016;
      cyc();
      chk("soft_repress", {31'd0, soft_drop}, 32'd1);
      for (int i = 0; i < 3; i++) frame();
      chk("soft_repeat", n_sd, 32'd2);
      keycode = 16'h0000;
      cyc(); cyc();

`ifdef KEY_ACTION_PAUSE_EN
      // Esc freezes left auto-repeat mid-delay
      clr();
      keycode = 16'h0004;
      cyc();
      frame(); frame(); frame();
      keycode = 16'h2904;
      cyc();
      chk("pause_on", {31'd0, pause}, 32'd1);
      for (int i = 0; i < 20; i++) frame();
      chk("pause_left", n_l, 32'd1);
      keycode = 16'h0000;
      cyc(); cyc();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
